spike_rate_encoder: RTL and testbench



---
 rtl/spike_enc_pkg.sv | 21 ++
 rtl/spike_coder_lane.sv | 47 ++++
 rtl/spike_rate_encoder.sv | 121 ++++++++++++
 tb/tb_spike_rate_encoder.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/spike_enc_pkg.sv
// Shared types and helpers for the spike rate encoder.
// The LFSR constants are only used when SPIKE_ENC_LFSR_EN is defined.
package spike_enc_pkg;

    typedef enum logic {IDLE = 1'b0, ENCODE = 1'b1} enc_state_e;

    // Right-shift Galois mask for x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LFSR_TAPS       = 16'hB400;
    localparam int          LFSR_ROT_STRIDE = 5;

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        return (x >> 1) ^ ({16{x[0]}} & LFSR_TAPS);
    endfunction

    function automatic logic [15:0] rotl16(input logic [15:0] x, input int n);
        int s;
        s = n % 16;
        return (x << s) | (x >> (16 - s));
    endfunction

endpackage

// File: rtl/spike_coder_lane.sv
// One pixel's spike coder: sigma-delta accumulator by default,
// LFSR threshold compare when SPIKE_ENC_LFSR_EN is defined.
module spike_coder_lane
    import spike_enc_pkg::*;
#(
    parameter int PIXEL_W = 8,
    parameter int LANE    = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               init,
    input  logic               adv,
    input  logic [PIXEL_W-1:0] pixel,
`ifdef SPIKE_ENC_LFSR_EN
    input  logic [15:0]        lfsr,
`endif
    output logic               spike
);

`ifdef SPIKE_ENC_LFSR_EN
    logic [15:0]        rot;
    logic [PIXEL_W-1:0] rnd;
    logic               unused_lane;

    // Each lane sees a differently rotated view of the shared LFSR
    assign rot         = rotl16(lfsr, LFSR_ROT_STRIDE * LANE);
    assign rnd         = rot[PIXEL_W-1:0];
    assign spike       = pixel > rnd;
    assign unused_lane = ^{clk, rst, init, adv};
`else
    localparam logic [PIXEL_W-1:0] ACC_INIT = {1'b1, {(PIXEL_W-1){1'b0}}};

    logic [PIXEL_W-1:0] acc_q;
    logic [PIXEL_W:0]   sum;

    assign sum   = {1'b0, acc_q} + {1'b0, pixel};
    assign spike = sum[PIXEL_W];

    // init wins over adv so an end-of-frame swap starts the new frame cleanly
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       acc_q <= '0;
        else if (init) acc_q <= ACC_INIT;
        else if (adv)  acc_q <= sum[PIXEL_W-1:0];
    end
`endif

endmodule

// File: rtl/spike_rate_encoder.sv
// Frame-to-spike-train encoder with a one-deep shadow frame buffer.
// Define SPIKE_ENC_LFSR_EN for stochastic LFSR coding; default is sigma-delta.
module spike_rate_encoder
    import spike_enc_pkg::*;
#(
    parameter int          N_INPUTS   = 4,
    parameter int          PIXEL_W    = 8,
    parameter int          N_STEPS    = 10,
    parameter int          STEP_CNT_W = 5,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load_valid,
    output logic                         load_ready,
    input  logic [N_INPUTS*PIXEL_W-1:0]  load_data,
    input  logic                         sample,
    output logic                         sample_ready,
    output logic [N_INPUTS-1:0]          in_spikes,
    output logic                         frame_done
);

    localparam logic [STEP_CNT_W-1:0] LAST_STEP = STEP_CNT_W'(N_STEPS - 1);

    enc_state_e                        state_q, state_d;
    logic [N_INPUTS-1:0][PIXEL_W-1:0]  active_q, shadow_q, load_pix;
    logic                              shadow_valid_q;
    logic [STEP_CNT_W-1:0]             step_cnt_q, step_cnt_d;
    logic                              frame_done_q, frame_done_d;
    logic                              load_fire, swap, adv;
    logic [N_INPUTS-1:0]               lane_spk;

    assign load_pix     = load_data;
    assign load_ready   = !shadow_valid_q;
    assign load_fire    = load_valid && load_ready;
    assign sample_ready = (state_q == ENCODE);
    assign in_spikes    = sample_ready ? lane_spk : '0;
    assign frame_done   = frame_done_q;

    always_comb begin
        state_d      = state_q;
        step_cnt_d   = step_cnt_q;
        frame_done_d = 1'b0;
        swap         = 1'b0;
        adv          = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (shadow_valid_q) begin
                    swap       = 1'b1;
                    step_cnt_d = '0;
                    state_d    = ENCODE;
                end
            end
            ENCODE: begin
                if (sample) begin
                    adv = 1'b1;
                    if (step_cnt_q == LAST_STEP) begin
                        frame_done_d = 1'b1;
                        step_cnt_d   = '0;
                        // Pending frame continues without a bubble
                        if (shadow_valid_q) swap    = 1'b1;
                        else                state_d = IDLE;
                    end else begin
                        step_cnt_d = step_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            step_cnt_q     <= '0;
            frame_done_q   <= 1'b0;
            shadow_valid_q <= 1'b0;
            shadow_q       <= '0;
            active_q       <= '0;
        end else begin
            state_q        <= state_d;
            step_cnt_q     <= step_cnt_d;
            frame_done_q   <= frame_done_d;
            // load_fire and swap are exclusive since load_ready needs an empty shadow
            shadow_valid_q <= load_fire | (shadow_valid_q & ~swap);
            if (load_fire) shadow_q <= load_pix;
            if (swap)      active_q <= shadow_q;
        end
    end

`ifdef SPIKE_ENC_LFSR_EN
    logic [15:0] lfsr_q;

    // Free-running across frames; only reset restores the seed
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      lfsr_q <= LFSR_SEED;
        else if (adv) lfsr_q <= lfsr_next(lfsr_q);
    end
`else
    logic unused_seed;
    assign unused_seed = ^LFSR_SEED;
`endif

    for (genvar i = 0; i < N_INPUTS; i++) begin : g_lane
        spike_coder_lane #(
            .PIXEL_W (PIXEL_W),
            .LANE    (i)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .init  (swap),
            .adv   (adv),
            .pixel (active_q[i]),
`ifdef SPIKE_ENC_LFSR_EN
            .lfsr  (lfsr_q),
`endif
            .spike (lane_spk[i])
        );
    end

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Directed bench for spike_rate_encoder: reset, latency, counts, back-to-back, backpressure.
module tb_spike_rate_encoder;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int NS = 10;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           load_valid = 1'b0;
    logic           load_ready;
    logic [N*W-1:0] load_data = '0;
    logic           sample = 1'b0;
    logic           sample_ready;
    logic [N-1:0]   in_spikes;
    logic           frame_done;

    int nvec = 0;
    int nerr = 0;

    spike_rate_encoder #(
        .N_INPUTS(N), .PIXEL_W(W), .N_STEPS(NS), .STEP_CNT_W(5), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_data    (load_data),
        .sample       (sample),
        .sample_ready (sample_ready),
        .in_spikes    (in_spikes),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock; a producer drops load_valid once its frame is taken
    task automatic step();
        logic lf;
        lf = load_valid && load_ready;
        @(posedge clk);
        #1;
        sample = 1'b0;
        if (lf) load_valid = 1'b0;
    endtask

    task automatic run_frame(input string tag, input logic [N-1:0][7:0] exp_cnt);
        int cnt [N];
        for (int i = 0; i < N; i++) cnt[i] = 0;
        for (int k = 0; k < NS; k++) begin
            chk({tag, "_srdy"}, 32'(sample_ready), 32'd1);
            for (int i = 0; i < N; i++) cnt[i] += int'(in_spikes[i]);
            sample = 1'b1;
            step();
            chk({tag, "_fdone"}, 32'(frame_done), 32'(k == NS - 1));
        end
        for (int i = 0; i < N; i++) begin
`ifdef SPIKE_ENC_LFSR_EN
            if (exp_cnt[i] == 8'd0) chk({tag, "_cnt0"}, 32'(cnt[i]), 32'd0);
`else
            chk({tag, "_cnt"}, 32'(cnt[i]), 32'(exp_cnt[i]));
`endif
        end
    endtask

    // Pixel i sits at bits [i*8 +: 8]; listed MSB lane first
    localparam logic [N*W-1:0] FRAME_A = {8'd0, 8'd64, 8'd128, 8'd255};
    localparam logic [N*W-1:0] FRAME_B = {8'd255, 8'd30, 8'd100, 8'd200};
    localparam logic [N*W-1:0] FRAME_C = {8'd0, 8'd0, 8'd0, 8'd128};

    initial begin
        logic [N-1:0][7:0] cnt_a, cnt_b, cnt_c;
        cnt_a = {8'd0, 8'd3, 8'd5, 8'd10};
        cnt_b = {8'd10, 8'd1, 8'd4, 8'd8};
        cnt_c = {8'd0, 8'd0, 8'd0, 8'd5};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_lrdy",  32'(load_ready),   32'd1);
        chk("rst_srdy",  32'(sample_ready), 32'd0);
        chk("rst_spk",   32'(in_spikes),    32'd0);
        chk("rst_fdone", 32'(frame_done),   32'd0);

        // sample pulses while idle are ignored
        for (int k = 0; k < 2; k++) begin
            sample = 1'b1;
            step();
            chk("idle_srdy",  32'(sample_ready), 32'd0);
            chk("idle_spk",   32'(in_spikes),    32'd0);
            chk("idle_fdone", 32'(frame_done),   32'd0);
        end

        // Latency: accept, shadow write, swap
        load_valid = 1'b1; load_data = FRAME_A;
        step();
        chk("lat_t1_srdy", 32'(sample_ready), 32'd0);
        step();
        chk("lat_t2_srdy", 32'(sample_ready), 32'd1);
        chk("lat_lrdy",    32'(load_ready),   32'd1);
`ifndef SPIKE_ENC_LFSR_EN
        chk("a_vec0", 32'(in_spikes), 32'h3);
`endif
        run_frame("a1", cnt_a);
        chk("a1_idle_srdy", 32'(sample_ready), 32'd0);
        chk("a1_idle_spk",  32'(in_spikes),    32'd0);
        step();
        chk("a1_fdone_pulse", 32'(frame_done), 32'd0);

        // A active, B in shadow, C held against a full shadow
        load_valid = 1'b1; load_data = FRAME_A;
        step(); step();
        load_valid = 1'b1; load_data = FRAME_B;
        step();
        chk("b_shadow_lrdy", 32'(load_ready), 32'd0);
        load_valid = 1'b1; load_data = FRAME_C;
        step();
        chk("bp_lrdy", 32'(load_ready), 32'd0);
        run_frame("a2", cnt_a);
        chk("b2b_srdy", 32'(sample_ready), 32'd1);
        chk("b2b_lrdy", 32'(load_ready),   32'd1);
`ifndef SPIKE_ENC_LFSR_EN
        chk("b_vec0", 32'(in_spikes), 32'h9);
`endif
        run_frame("b", cnt_b);
        chk("c_srdy", 32'(sample_ready), 32'd1);
`ifndef SPIKE_ENC_LFSR_EN
        chk("c_vec0", 32'(in_spikes), 32'h1);
`endif
        run_frame("c", cnt_c);
        chk("c_idle_srdy", 32'(sample_ready), 32'd0);
        chk("c_idle_lrdy", 32'(load_ready),   32'd1);

        // Reset mid-frame with a frame pending in shadow
        load_valid = 1'b1; load_data = FRAME_A;
        step(); step();
        for (int k = 0; k < 3; k++) begin
            sample = 1'b1;
            step();
        end
        load_valid = 1'b1; load_data = FRAME_B;
        step();
        chk("pre_rst_lrdy", 32'(load_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk("mid_rst_srdy", 32'(sample_ready), 32'd0);
        chk("mid_rst_spk",  32'(in_spikes),    32'd0);
        chk("mid_rst_lrdy", 32'(load_ready),   32'd1);
        load_valid = 1'b0;
        step();
        chk("mid_rst_fdone", 32'(frame_done), 32'd0);
        rst = 1'b0;
        step(); step(); step();
        chk("post_rst_srdy", 32'(sample_ready), 32'd0);
        chk("post_rst_spk",  32'(in_spikes),    32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
